// File: rtl/ht_cmd_arbiter.sv
// ht_cmd_arbiter: shares one hash-table command port among NUM_REQ requesters and routes in-order results back by tag
// Ports: clk_i/rst_n_i (async active-low); req_valid_i/req_key_i/req_value_i/req_opcode_i -> req_ready_o (one-hot grant);
//   ht_valid_o/ht_ready_i with registered ht_key_o/ht_value_o/ht_opcode_o; ht_res_valid_i/ht_res_ready_o/ht_res_data_i;
//   res_valid_o (one-hot)/res_data_o/res_ready_i; outstanding_o (tag FIFO occupancy); err_o (sticky unexpected-result flag).
// Build option: define HT_CMD_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module ht_cmd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int KEY_WIDTH       = 32,
  parameter int VALUE_WIDTH     = 16,
  parameter int OPCODE_WIDTH    = 2,
  parameter int RES_WIDTH       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]      req_key_i,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0]    req_value_i,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0]   req_opcode_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              ht_valid_o,
  input  logic                              ht_ready_i,
  output logic [KEY_WIDTH-1:0]              ht_key_o,
  output logic [VALUE_WIDTH-1:0]            ht_value_o,
  output logic [OPCODE_WIDTH-1:0]           ht_opcode_o,
  input  logic                              ht_res_valid_i,
  output logic                              ht_res_ready_o,
  input  logic [RES_WIDTH-1:0]              ht_res_data_i,
  output logic [NUM_REQ-1:0]                res_valid_o,
  output logic [RES_WIDTH-1:0]              res_data_o,
  input  logic [NUM_REQ-1:0]                res_ready_i,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              err_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  logic [IW-1:0] gnt, head;
  logic          gnt_any, arb_en, push, pop, empty;
  logic [IW-1:0] tags [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign empty  = outstanding_o == '0;
  // a same-cycle pop deliberately does not free a slot: the registered count gates arbitration
  assign arb_en = rst_n_i && (!ht_valid_o || ht_ready_i) && (outstanding_o < CW'(MAX_OUTSTANDING));
`ifdef HT_CMD_ARB_STRICT_PRIO_EN
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid_i[i]) begin
        gnt     = IW'(i);
        gnt_any = 1'b1;
      end
  end
`else
  logic [IW-1:0] last_grant;
  // search starts just after the previous winner and wraps modulo NUM_REQ
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++)
      if (!gnt_any && req_valid_i[(int'(last_grant) + i) % NUM_REQ]) begin
        gnt     = IW'((int'(last_grant) + i) % NUM_REQ);
        gnt_any = 1'b1;
      end
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) last_grant <= IW'(NUM_REQ - 1);
    else if (push) last_grant <= gnt;
`endif
  assign push           = arb_en && gnt_any;
  assign req_ready_o    = push ? ONE << gnt : '0;
  assign head           = tags[rd_ptr];
  assign res_valid_o    = (ht_res_valid_i && !empty) ? ONE << head : '0;
  assign res_data_o     = ht_res_data_i;
  // with no tag outstanding a stray result is swallowed rather than stalling the hash table
  assign ht_res_ready_o = empty || res_ready_i[head];
  assign pop            = ht_res_valid_i && !empty && res_ready_i[head];
  always_ff @(posedge clk_i)
    if (push) tags[wr_ptr] <= gnt;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      ht_valid_o    <= 1'b0;
      ht_key_o      <= '0;
      ht_value_o    <= '0;
      ht_opcode_o   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      ht_valid_o    <= push || (ht_valid_o && !ht_ready_i);
      if (push) begin
        ht_key_o    <= req_key_i[gnt*KEY_WIDTH +: KEY_WIDTH];
        ht_value_o  <= req_value_i[gnt*VALUE_WIDTH +: VALUE_WIDTH];
        ht_opcode_o <= req_opcode_i[gnt*OPCODE_WIDTH +: OPCODE_WIDTH];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      outstanding_o <= outstanding_o + CW'(push) - CW'(pop);
      if (ht_res_valid_i && empty) err_o <= 1'b1;
    end
endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// tb_ht_cmd_arbiter: directed self-checking bench for ht_cmd_arbiter
module tb_ht_cmd_arbiter;
  localparam logic [1:0] OP_INSERT = 2'd1;
  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic [3:0]   req_valid_i = '0;
  logic [127:0] req_key_i = '0;
  logic [63:0]  req_value_i = '0;
  logic [7:0]   req_opcode_i = '0;
  logic [3:0]   req_ready_o;
  logic         ht_valid_o;
  logic         ht_ready_i = 1'b0;
  logic [31:0]  ht_key_o;
  logic [15:0]  ht_value_o;
  logic [1:0]   ht_opcode_o;
  logic         ht_res_valid_i = 1'b0;
  logic         ht_res_ready_o;
  logic [63:0]  ht_res_data_i = '0;
  logic [3:0]   res_valid_o;
  logic [63:0]  res_data_o;
  logic [3:0]   res_ready_i = '0;
  logic [3:0]   outstanding_o;
  logic         err_o;
  int errors = 0;
  int checks = 0;

  ht_cmd_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_key_i(req_key_i), .req_value_i(req_value_i),
    .req_opcode_i(req_opcode_i), .req_ready_o(req_ready_o),
    .ht_valid_o(ht_valid_o), .ht_ready_i(ht_ready_i), .ht_key_o(ht_key_o),
    .ht_value_o(ht_value_o), .ht_opcode_o(ht_opcode_o),
    .ht_res_valid_i(ht_res_valid_i), .ht_res_ready_o(ht_res_ready_o), .ht_res_data_i(ht_res_data_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_n_i = 1'b0;
    req_valid_i = '0;
    ht_ready_i = 1'b0;
    ht_res_valid_i = 1'b0;
    res_ready_i = '0;
    req_key_i = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    req_value_i = {16'h0d03, 16'h0d02, 16'h0d01, 16'h0d00};
    req_opcode_i = {2'd3, 2'd2, 2'd1, 2'd0};
    tick();
    tick();
    rst_n_i = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    #1;
    checks++; if (ht_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ht_valid: got %b want 0", ht_valid_o); end
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (ht_key_o !== 32'd0) begin errors++; $display("FAIL reset_key: got %h want 0", ht_key_o); end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    ht_ready_i = 1'b1;
    req_valid_i = 4'b0010;
    req_key_i[63:32] = 32'h0100_0000;
    req_value_i[31:16] = 16'h1234;
    req_opcode_i[3:2] = OP_INSERT;
    #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", req_ready_o); end
    tick();
    req_valid_i = '0;
    checks++; if (ht_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", ht_valid_o); end
    checks++; if (ht_key_o !== 32'h0100_0000) begin errors++; $display("FAIL single_key: got %h want 01000000", ht_key_o); end
    checks++; if (ht_value_o !== 16'h1234) begin errors++; $display("FAIL single_value: got %h want 1234", ht_value_o); end
    checks++; if (ht_opcode_o !== OP_INSERT) begin errors++; $display("FAIL single_opcode: got %0d want %0d", ht_opcode_o, OP_INSERT); end
    checks++; if (outstanding_o !== 4'd1) begin errors++; $display("FAIL single_outstanding: got %0d want 1", outstanding_o); end
    tick();
    ht_res_valid_i = 1'b1;
    ht_res_data_i = 64'hdead_beef_0000_0001;
    res_ready_i = 4'b0010;
    #1;
    checks++; if (res_valid_o !== 4'b0010) begin errors++; $display("FAIL single_res_valid: got %b want 0010", res_valid_o); end
    checks++; if (res_data_o !== 64'hdead_beef_0000_0001) begin errors++; $display("FAIL single_res_data: got %h want deadbeef00000001", res_data_o); end
    checks++; if (ht_res_ready_o !== 1'b1) begin errors++; $display("FAIL single_res_ready: got %b want 1", ht_res_ready_o); end
    tick();
    ht_res_valid_i = 1'b0;
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL single_drained: got %0d want 0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err_o); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    logic [31:0] exp_k;
    do_reset();
    ht_ready_i = 1'b1;
    req_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
`ifdef HT_CMD_ARB_STRICT_PRIO_EN
      exp_g = 4'b0001;
      exp_k = 32'h100;
`else
      exp_g = 4'b0001 << (i % 4);
      exp_k = 32'h100 + 32'(i % 4);
`endif
      #1;
      checks++; if (req_ready_o !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready_o, exp_g); end
      tick();
      checks++; if (ht_key_o !== exp_k) begin errors++; $display("FAIL rr_key[%0d]: got %h want %h", i, ht_key_o, exp_k); end
    end
    #1;
    checks++; if (outstanding_o !== 4'd8) begin errors++; $display("FAIL rr_full_count: got %0d want 8", outstanding_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL rr_full_stall: got %b want 0000", req_ready_o); end
  endtask

  task automatic test_backpressure;
    logic [3:0] exp_g;
    logic [31:0] exp_k;
    do_reset();
    req_valid_i = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready_o); end
      checks++; if ({ht_valid_o, ht_key_o, ht_value_o, ht_opcode_o} !== {1'b1, 32'h100, 16'h0d00, 2'd0})
        begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%h/%0d want 1/100/0d00/0", i, ht_valid_o, ht_key_o, ht_value_o, ht_opcode_o); end
      tick();
    end
    ht_ready_i = 1'b1;
`ifdef HT_CMD_ARB_STRICT_PRIO_EN
    exp_g = 4'b0001;
    exp_k = 32'h100;
`else
    exp_g = 4'b0010;
    exp_k = 32'h101;
`endif
    #1;
    checks++; if (req_ready_o !== exp_g) begin errors++; $display("FAIL bp_release_grant: got %b want %b", req_ready_o, exp_g); end
    tick();
    checks++; if (ht_key_o !== exp_k) begin errors++; $display("FAIL bp_next_key: got %h want %h", ht_key_o, exp_k); end
    checks++; if (outstanding_o !== 4'd2) begin errors++; $display("FAIL bp_outstanding: got %0d want 2", outstanding_o); end
  endtask

  task automatic test_full_fifo;
    do_reset();
    ht_ready_i = 1'b1;
    req_valid_i = 4'b0001;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (outstanding_o !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", outstanding_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL full_stall: got %b want 0000", req_ready_o); end
    ht_res_valid_i = 1'b1;
    res_ready_i = 4'b1111;
    #1;
    checks++; if (res_valid_o !== 4'b0001) begin errors++; $display("FAIL full_res_valid: got %b want 0001", res_valid_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL full_same_cycle: got %b want 0000", req_ready_o); end
    tick();
    ht_res_valid_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 4'd7) begin errors++; $display("FAIL full_after_pop: got %0d want 7", outstanding_o); end
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL full_ninth_grant: got %b want 0001", req_ready_o); end
    tick();
    checks++; if (outstanding_o !== 4'd8) begin errors++; $display("FAIL full_refill: got %0d want 8", outstanding_o); end
  endtask

  task automatic test_ordering;
    do_reset();
    ht_ready_i = 1'b1;
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = 4'b1000;
    tick();
    req_valid_i = 4'b0000;
    checks++; if (outstanding_o !== 4'd3) begin errors++; $display("FAIL ord_count: got %0d want 3", outstanding_o); end
    ht_res_valid_i = 1'b1;
    res_ready_i = 4'b1110;
    #1;
    checks++; if ({res_valid_o, ht_res_ready_o} !== {4'b0100, 1'b1}) begin errors++; $display("FAIL ord_first: got %b/%b want 0100/1", res_valid_o, ht_res_ready_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({res_valid_o, ht_res_ready_o} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL ord_stall[%0d]: got %b/%b want 0001/0", i, res_valid_o, ht_res_ready_o); end
      tick();
    end
    res_ready_i = 4'b1111;
    #1;
    checks++; if ({res_valid_o, ht_res_ready_o} !== {4'b0001, 1'b1}) begin errors++; $display("FAIL ord_second: got %b/%b want 0001/1", res_valid_o, ht_res_ready_o); end
    tick();
    #1;
    checks++; if ({res_valid_o, ht_res_ready_o} !== {4'b1000, 1'b1}) begin errors++; $display("FAIL ord_third: got %b/%b want 1000/1", res_valid_o, ht_res_ready_o); end
    tick();
    ht_res_valid_i = 1'b0;
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL ord_drained: got %0d want 0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ord_err: got %b want 0", err_o); end
  endtask

  task automatic test_error_reset;
    do_reset();
    ht_res_valid_i = 1'b1;
    #1;
    checks++; if ({ht_res_ready_o, res_valid_o} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL err_drop: got %b/%b want 1/0000", ht_res_ready_o, res_valid_o); end
    tick();
    ht_res_valid_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_o); end
    tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    ht_ready_i = 1'b1;
    req_valid_i = 4'b1111;
    tick();
    tick();
    tick();
    #2;
    rst_n_i = 1'b0;
    ht_res_valid_i = 1'b1;
    #1;
    checks++; if ({ht_valid_o, req_ready_o, res_valid_o, outstanding_o, err_o} !== 14'd0)
      begin errors++; $display("FAIL midreset_outputs: got %b/%b/%b/%0d/%b want all 0", ht_valid_o, req_ready_o, res_valid_o, outstanding_o, err_o); end
    checks++; if ({ht_key_o, ht_value_o, ht_opcode_o} !== 50'd0) begin errors++; $display("FAIL midreset_fields: got %h/%h/%0d want 0", ht_key_o, ht_value_o, ht_opcode_o); end
    req_valid_i = '0;
    tick();
    rst_n_i = 1'b1;
    #1;
    checks++; if ({ht_res_ready_o, res_valid_o} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL postreset_drop: got %b/%b want 1/0000", ht_res_ready_o, res_valid_o); end
    tick();
    ht_res_valid_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL postreset_err: got %b want 1", err_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_fifo();
    test_ordering();
    test_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
